argmax_seq: RTL and testbench

Sequential argmax controller. It accepts a frame of N unsigned M-bit elements over a valid/ready stream, one per cycle, through a single shared compare/select slice. It returns the frame maximum and its index over a second valid/ready handshake. It is the area-lean counterpart of the fully unrolled combinational argmax and sits between a feature/score producer and the downstream decision logic.

---
 rtl/argmax_seq_if.sv | 25 ++
 rtl/argmax_seq.sv | 130 +++++++++++++
 tb/tb_argmax_seq.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/argmax_seq_if.sv
// Stream-side bundle for argmax_seq: element input stream and result output stream.
interface argmax_seq_if #(
  parameter int M  = 32,
  parameter int IW = 4
);
  logic          in_valid;
  logic          in_ready;
  logic [M-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [M-1:0]  max;
  logic [IW-1:0] ind;

  // Producer / consumer side (drives elements, takes results).
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, max, ind
  );

  // argmax block side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, max, ind
  );
endinterface

// File: rtl/argmax_seq.sv
// Sequential argmax: scans one element per cycle through a single compare
// slice and reports the frame maximum plus its earliest index.
module argmax_seq #(
  parameter int N  = 16,
  parameter int M  = 32,
  parameter int IW = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  argmax_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter is one bit wider than the index so that cnt==N is representable.
  localparam logic [IW:0] N_CNT = (IW+1)'(N);
  localparam logic [IW:0] CNT_ZERO = {(IW+1){1'b0}};
  localparam logic [IW:0] CNT_ONE  = {{IW{1'b0}}, 1'b1};

  state_e        state_q, state_d;
  logic [IW:0]   cnt_q, cnt_d;
  logic [M-1:0]  max_q, max_d;
  logic [IW-1:0] ind_q, ind_d;
  logic          busy_q, busy_d;
  logic          out_valid_q, out_valid_d;

  logic          in_ready_s;
  logic          accept_s;
  logic [IW:0]   cnt_inc_s;

  // in_ready depends only on state and abort so an aborting cycle never accepts.
  assign in_ready_s = (state_q == RUN) & ~abort;
  assign accept_s   = bus.in_valid & in_ready_s;
  assign cnt_inc_s  = cnt_q + CNT_ONE;

  // Next-state, counter and running-max selection.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    max_d       = max_q;
    ind_d       = ind_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (abort) begin
          // Partial max/ind are left as-is; they are meaningless outside DONE.
          state_d = IDLE;
        end else if (accept_s) begin
          if (cnt_q == CNT_ZERO) begin
            max_d = bus.in_data;
            ind_d = {IW{1'b0}};
          end else if (bus.in_data > max_q) begin
            // Strict compare keeps the earliest index on ties.
            max_d = bus.in_data;
            ind_d = cnt_q[IW-1:0];
          end else begin
            max_d = max_q;
            ind_d = ind_q;
          end
          cnt_d = cnt_inc_s;
          if (cnt_inc_s == N_CNT) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          if (start) begin
            state_d = RUN;
            cnt_d   = CNT_ZERO;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
    busy_d      = (state_d != IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State, datapath and status flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= CNT_ZERO;
      max_q       <= {M{1'b0}};
      ind_q       <= {IW{1'b0}};
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      max_q       <= max_d;
      ind_q       <= ind_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign busy          = busy_q;
  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.max       = max_q;
  assign bus.ind       = ind_q;

endmodule

// File: tb/tb_argmax_seq.sv
// Self-checking bench for argmax_seq with a queue/array-based reference model.
module tb_argmax_seq;
  localparam int N  = 16;
  localparam int M  = 32;
  localparam int IW = 4;

  logic clk;
  logic rst;
  logic start;
  logic abort;
  logic busy;

  argmax_seq_if #(.M(M), .IW(IW)) bus ();

  argmax_seq #(.N(N), .M(M), .IW(IW)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .abort (abort),
    .busy  (busy),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [M-1:0]  fr [N];
  logic [M-1:0]  exp_max;
  logic [IW-1:0] exp_ind;

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: find the largest value, then the first position holding it.
  task automatic ref_model(output logic [M-1:0] m, output logic [IW-1:0] k);
    logic [M-1:0] best;
    best = fr[0];
    foreach (fr[i]) if (fr[i] > best) best = fr[i];
    m = best;
    k = '0;
    for (int i = N - 1; i >= 0; i--) if (fr[i] == best) k = IW'(i);
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_busy"},   {63'd0, busy},          64'd0);
    check_val({tag, "_rdy"},    {63'd0, bus.in_ready},  64'd0);
    check_val({tag, "_ovalid"}, {63'd0, bus.out_valid}, 64'd0);
  endtask

  // Pulse start from IDLE; in_ready must be up the following cycle.
  task automatic begin_frame();
    start = 1'b1;
    step();
    start = 1'b0;
    check_val("rdy_after_start", {63'd0, bus.in_ready}, 64'd1);
  endtask

  // Offer fr[0..n-1] with random gaps; returns the number of cycles spent.
  task automatic feed_n(input int n, input int gap_pct, output int cycles);
    int idx;
    int budget;
    bit acc;
    idx = 0;
    cycles = 0;
    budget = 400;
    while (idx < n && budget > 0) begin
      bus.in_valid = ($urandom_range(0, 99) >= gap_pct);
      bus.in_data  = bus.in_valid ? fr[idx] : M'($urandom);
      acc = bus.in_valid & bus.in_ready;
      step();
      cycles++;
      budget--;
      if (acc) idx++;
    end
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    if (idx < n) check_val("feed_timeout", 64'(idx), 64'(n));
  endtask

  task automatic check_result(input string tag);
    ref_model(exp_max, exp_ind);
    check_val({tag, "_ovalid"}, {63'd0, bus.out_valid}, 64'd1);
    check_val({tag, "_max"},    64'(bus.max),           64'(exp_max));
    check_val({tag, "_ind"},    64'(bus.ind),           64'(exp_ind));
  endtask

  // Hold out_ready low and confirm the result stays put.
  task automatic hold_check(input int k);
    bus.out_ready = 1'b0;
    for (int i = 0; i < k; i++) begin
      step();
      check_val("hold_ovalid", {63'd0, bus.out_valid}, 64'd1);
      check_val("hold_max",    64'(bus.max),           64'(exp_max));
      check_val("hold_ind",    64'(bus.ind),           64'(exp_ind));
    end
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check_idle("release");
  endtask

  task automatic full_frame(input string tag, input int gap_pct, input int hold);
    int cyc;
    begin_frame();
    feed_n(N, gap_pct, cyc);
    check_result(tag);
    hold_check(hold);
    release_result();
  endtask

  initial begin
    int cyc;
    logic [M-1:0] tbl [N];
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    check_idle("reset");
    check_val("reset_max", 64'(bus.max), 64'd0);
    check_val("reset_ind", 64'(bus.ind), 64'd0);

    // IDLE ignores elements and out_ready.
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    check_idle("idle_ignore");

    // Directed frame, continuous stream, latency N+1.
    tbl = '{32'd5, 32'd9, 32'd3, 32'd9, 32'd2, 32'd4, 32'd6, 32'd8,
            32'd1, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'd9, 32'd3, 32'd2, 32'd1};
    fr = tbl;
    begin_frame();
    feed_n(N, 0, cyc);
    check_val("latency", 64'(cyc + 1), 64'(N + 1));
    check_result("directed");
    check_val("directed_ind_const", 64'(bus.ind), 64'd11);
    release_result();

    // All equal: earliest index wins.
    foreach (fr[i]) fr[i] = 32'h7;
    full_frame("ties", 0, 1);

    // Unsigned compare: MSB-set value at the last slot.
    foreach (fr[i]) fr[i] = 32'h7FFF_FFFF;
    fr[N-1] = 32'h8000_0000;
    full_frame("unsigned", 0, 1);
    check_val("unsigned_ind_const", 64'(exp_ind), 64'd15);

    // Random frames with gaps and a stalled consumer.
    for (int f = 0; f < 6; f++) begin
      foreach (fr[i]) fr[i] = (f % 2 == 0) ? M'($urandom_range(0, 7)) : M'($urandom);
      full_frame("random", 50, 5);
    end

    // Back-to-back: out_ready and start in the same DONE cycle.
    foreach (fr[i]) fr[i] = M'($urandom);
    begin_frame();
    feed_n(N, 0, cyc);
    check_result("b2b_first");
    bus.out_ready = 1'b1;
    start = 1'b1;
    step();
    bus.out_ready = 1'b0;
    start = 1'b0;
    check_val("b2b_rdy",    {63'd0, bus.in_ready},  64'd1);
    check_val("b2b_busy",   {63'd0, busy},          64'd1);
    check_val("b2b_ovalid", {63'd0, bus.out_valid}, 64'd0);
    foreach (fr[i]) fr[i] = M'($urandom_range(0, 1000));
    fr[4] = 32'd5000;
    feed_n(N, 0, cyc);
    check_result("b2b_second");
    check_val("b2b_ind4", 64'(bus.ind), 64'd4);
    release_result();

    // Abort after 7 accepts; the abort-cycle element is refused.
    foreach (fr[i]) fr[i] = M'($urandom);
    begin_frame();
    feed_n(7, 0, cyc);
    abort = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 32'hFFFF_FFFF;
    #1;
    check_val("abort_rdy", {63'd0, bus.in_ready}, 64'd0);
    step();
    abort = 1'b0;
    bus.in_valid = 1'b0;
    check_idle("abort");
    step();
    step();
    check_idle("abort_later");
    foreach (fr[i]) fr[i] = M'($urandom_range(0, 15));
    fr[2] = 32'h10;
    begin_frame();
    feed_n(N, 30, cyc);
    check_result("post_abort");
    check_val("post_abort_max", 64'(bus.max), 64'h10);
    check_val("post_abort_ind", 64'(bus.ind), 64'd2);
    // abort in DONE must not drop the result.
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_val("abort_done_ovalid", {63'd0, bus.out_valid}, 64'd1);
    check_val("abort_done_max",    64'(bus.max),           64'h10);
    release_result();

    // Reset mid-frame after 3 accepts.
    foreach (fr[i]) fr[i] = M'($urandom) | 32'h1;
    begin_frame();
    feed_n(3, 0, cyc);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle("rst_run");
    check_val("rst_run_max", 64'(bus.max), 64'd0);
    check_val("rst_run_ind", 64'(bus.ind), 64'd0);

    // Reset while a result is pending.
    foreach (fr[i]) fr[i] = M'($urandom) | 32'h1;
    begin_frame();
    feed_n(N, 0, cyc);
    check_result("pre_rst_done");
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle("rst_done");
    check_val("rst_done_max", 64'(bus.max), 64'd0);
    check_val("rst_done_ind", 64'(bus.ind), 64'd0);

    // Clean frame after reset.
    foreach (fr[i]) fr[i] = M'($urandom);
    full_frame("post_rst", 20, 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
